// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern selector: samples buttons once per frame at the start
// of vertical blanking and commits pattern/invert/auto/banner changes during blanking.
module pattern_sequencer #(
  parameter int unsigned NUM_PATTERNS  = 6,
  parameter int unsigned AUTO_FRAMES   = 300,
  parameter int unsigned BANNER_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_auto,
  input  logic       btn_invert,
  output logic [3:0] pattern_sel,
  output logic       invert,
  output logic       auto_mode,
  output logic       banner,
  output logic       frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BTN_W  = 4;
  localparam int unsigned B_NEXT = 0;
  localparam int unsigned B_PREV = 1;
  localparam int unsigned B_AUTO = 2;
  localparam int unsigned B_INV  = 3;

  localparam logic [IDX_W-1:0] IDX_MAX     = IDX_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'(AUTO_FRAMES - 1);
  localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_DECODE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               vblank_q, vblank_d;
  logic [BTN_W-1:0]   btn_cur_q, btn_cur_d;
  logic [BTN_W-1:0]   btn_old_q, btn_old_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               invert_q, invert_d;
  logic               auto_q, auto_d;
  logic               banner_q, banner_d;
  logic               frame_start_q, frame_start_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   auto_cnt_q, auto_cnt_d;
  logic [CNT_W-1:0]   banner_cnt_q, banner_cnt_d;

  // Frame decode terms; only consumed while in DECODE.
  logic [BTN_W-1:0]   press_c;
  logic               tick_c;
  logic               man_next_c, man_prev_c, manual_c;
  logic               auto_expire_c, auto_step_c;
  logic [IDX_W-1:0]   idx_inc_c, idx_dec_c, idx_new_c;
  logic [CNT_W-1:0]   auto_cnt_new_c;
  logic               changed_c;

  assign tick_c  = vblank & ~vblank_q;
  assign press_c = btn_cur_q & ~btn_old_q;

  assign man_next_c = press_c[B_NEXT] & ~press_c[B_PREV];
  assign man_prev_c = press_c[B_PREV] & ~press_c[B_NEXT];
  assign manual_c   = man_next_c | man_prev_c;

  // Auto step only if running, not toggled this frame, and not overridden by a manual step.
  assign auto_expire_c = auto_q & (auto_cnt_q == AUTO_LAST);
  assign auto_step_c   = auto_expire_c & ~press_c[B_AUTO] & ~manual_c;

  assign idx_inc_c = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
  assign idx_dec_c = (idx_q == '0) ? IDX_MAX : idx_q - IDX_W'(1);

  always_comb begin
    idx_new_c = idx_q;
    if (man_next_c || auto_step_c) begin
      idx_new_c = idx_inc_c;
    end else if (man_prev_c) begin
      idx_new_c = idx_dec_c;
    end
  end

  always_comb begin
    auto_cnt_new_c = auto_cnt_q;
    if (press_c[B_AUTO]) begin
      auto_cnt_new_c = '0;
    end else if (auto_q) begin
      if (manual_c || auto_expire_c) begin
        auto_cnt_new_c = '0;
      end else begin
        auto_cnt_new_c = auto_cnt_q + CNT_W'(1);
      end
    end
  end

  assign changed_c = (idx_new_c != idx_q) | press_c[B_AUTO];

  // Next-state and next-value logic.
  always_comb begin
    state_d       = state_q;
    vblank_d      = vblank;
    btn_cur_d     = btn_cur_q;
    btn_old_d     = btn_old_q;
    idx_d         = idx_q;
    invert_d      = invert_q;
    auto_d        = auto_q;
    banner_d      = banner_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    auto_cnt_d    = auto_cnt_q;
    banner_cnt_d  = banner_cnt_q;

    unique case (state_q)
      ST_WAIT: begin
        if (tick_c) begin
          btn_cur_d     = {btn_invert, btn_auto, btn_prev, btn_next};
          btn_old_d     = btn_cur_q;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + CNT_W'(1);
          state_d       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        idx_d      = idx_new_c;
        invert_d   = invert_q ^ press_c[B_INV];
        auto_d     = auto_q ^ press_c[B_AUTO];
        auto_cnt_d = auto_cnt_new_c;
        if (changed_c) begin
          banner_d     = 1'b1;
          banner_cnt_d = BANNER_LAST;
        end else if (banner_q) begin
          if (banner_cnt_q == '0) begin
            banner_d = 1'b0;
          end else begin
            banner_cnt_d = banner_cnt_q - CNT_W'(1);
          end
        end
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // State registers; vblank_q resets high so a real rising edge is needed after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      vblank_q      <= 1'b1;
      btn_cur_q     <= '0;
      btn_old_q     <= '0;
      idx_q         <= '0;
      invert_q      <= 1'b0;
      auto_q        <= 1'b0;
      banner_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      auto_cnt_q    <= '0;
      banner_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      vblank_q      <= vblank_d;
      btn_cur_q     <= btn_cur_d;
      btn_old_q     <= btn_old_d;
      idx_q         <= idx_d;
      invert_q      <= invert_d;
      auto_q        <= auto_d;
      banner_q      <= banner_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      auto_cnt_q    <= auto_cnt_d;
      banner_cnt_q  <= banner_cnt_d;
    end
  end

  assign pattern_sel = idx_q;
  assign invert      = invert_q;
  assign auto_mode   = auto_q;
  assign banner      = banner_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: reset, stepping, wrap, auto cycling, invert,
// banner timing and mid-frame reset, with hand-computed expectations.
module tb_pattern_sequencer;

  logic        clk;
  logic        reset;
  logic        vblank;
  logic        btn_next, btn_prev, btn_auto, btn_invert;
  logic [3:0]  pattern_sel;
  logic        invert, auto_mode, banner, frame_start;
  logic [15:0] frame_cnt;

  int total;
  int bad;
  int fs_count;

  pattern_sequencer #(
    .NUM_PATTERNS (6),
    .AUTO_FRAMES  (4),
    .BANNER_FRAMES(120)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vblank     (vblank),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .btn_auto   (btn_auto),
    .btn_invert (btn_invert),
    .pattern_sel(pattern_sel),
    .invert     (invert),
    .auto_mode  (auto_mode),
    .banner     (banner),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock, sampling 1 time unit after the edge and tallying frame_start pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (frame_start === 1'b1) fs_count++;
  endtask

  task automatic tick();
    vblank = 1'b1;
    repeat (4) cyc();
    vblank = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; vblank = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0; btn_invert = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (2) cyc();
    fs_count = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pattern_sel !== 4'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", pattern_sel); end
    total++; if (invert !== 1'b0) begin bad++; $display("FAIL rst_invert got=%b exp=0", invert); end
    total++; if (auto_mode !== 1'b0) begin bad++; $display("FAIL rst_auto got=%b exp=0", auto_mode); end
    total++; if (banner !== 1'b0) begin bad++; $display("FAIL rst_banner got=%b exp=0", banner); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_next_held();
    do_reset();
    btn_next = 1'b1;
    vblank = 1'b1;
    cyc();
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL nh_fs_t1 got=%b exp=1", frame_start); end
    total++; if (pattern_sel !== 4'd0) begin bad++; $display("FAIL nh_sel_t1 got=%0d exp=0", pattern_sel); end
    cyc();
    total++; if (pattern_sel !== 4'd1) begin bad++; $display("FAIL nh_sel_t2 got=%0d exp=1", pattern_sel); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL nh_fs_t2 got=%b exp=0", frame_start); end
    total++; if (banner !== 1'b1) begin bad++; $display("FAIL nh_banner got=%b exp=1", banner); end
    repeat (2) cyc();
    vblank = 1'b0;
    repeat (3) cyc();
    tick();
    tick();
    total++; if (pattern_sel !== 4'd1) begin bad++; $display("FAIL nh_sel_end got=%0d exp=1", pattern_sel); end
    total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL nh_cnt got=%0d exp=3", frame_cnt); end
    total++; if (fs_count !== 3) begin bad++; $display("FAIL nh_fs_pulses got=%0d exp=3", fs_count); end
    btn_next = 1'b0;
  endtask

  task automatic test_prev_wrap_banner();
    int early_drop;
    do_reset();
    btn_prev = 1'b1;
    tick();
    btn_prev = 1'b0;
    total++; if (pattern_sel !== 4'd5) begin bad++; $display("FAIL pw_sel got=%0d exp=5", pattern_sel); end
    total++; if (banner !== 1'b1) begin bad++; $display("FAIL pw_banner0 got=%b exp=1", banner); end
    early_drop = 0;
    for (int i = 1; i <= 119; i++) begin
      tick();
      if (banner !== 1'b1 && early_drop == 0) early_drop = i;
    end
    total++; if (early_drop != 0) begin bad++; $display("FAIL pw_banner_hold dropped_at_tick=%0d exp=none", early_drop); end
    tick();
    total++; if (banner !== 1'b0) begin bad++; $display("FAIL pw_banner_end got=%b exp=0", banner); end
  endtask

  task automatic test_next_prev_same();
    btn_next = 1'b1; btn_prev = 1'b1;
    tick();
    btn_next = 1'b0; btn_prev = 1'b0;
    total++; if (pattern_sel !== 4'd5) begin bad++; $display("FAIL np_sel got=%0d exp=5", pattern_sel); end
    total++; if (banner !== 1'b0) begin bad++; $display("FAIL np_banner got=%b exp=0", banner); end
  endtask

  task automatic test_auto();
    logic [3:0] exp_sel [1:8];
    exp_sel = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    do_reset();
    btn_auto = 1'b1;
    tick();
    btn_auto = 1'b0;
    total++; if (auto_mode !== 1'b1) begin bad++; $display("FAIL au_mode got=%b exp=1", auto_mode); end
    total++; if (banner !== 1'b1) begin bad++; $display("FAIL au_banner got=%b exp=1", banner); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (pattern_sel !== exp_sel[i]) begin
        bad++; $display("FAIL au_cycle tick=%0d got=%0d exp=%0d", i, pattern_sel, exp_sel[i]);
      end
    end
    tick(); tick();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    total++; if (pattern_sel !== 4'd3) begin bad++; $display("FAIL au_manual got=%0d exp=3", pattern_sel); end
    repeat (3) tick();
    total++; if (pattern_sel !== 4'd3) begin bad++; $display("FAIL au_post_manual got=%0d exp=3", pattern_sel); end
    tick();
    total++; if (pattern_sel !== 4'd4) begin bad++; $display("FAIL au_resume got=%0d exp=4", pattern_sel); end
    btn_auto = 1'b1;
    tick();
    btn_auto = 1'b0;
    total++; if (auto_mode !== 1'b0) begin bad++; $display("FAIL au_off got=%b exp=0", auto_mode); end
    repeat (5) tick();
    total++; if (pattern_sel !== 4'd4) begin bad++; $display("FAIL au_stopped got=%0d exp=4", pattern_sel); end
  endtask

  task automatic test_invert();
    do_reset();
    btn_invert = 1'b1;
    repeat (2) cyc();
    btn_invert = 1'b0;
    tick();
    total++; if (invert !== 1'b0) begin bad++; $display("FAIL inv_short got=%b exp=0", invert); end
    btn_invert = 1'b1;
    vblank = 1'b1;
    cyc();
    total++; if (invert !== 1'b0) begin bad++; $display("FAIL inv_early got=%b exp=0", invert); end
    cyc();
    total++; if (invert !== 1'b1) begin bad++; $display("FAIL inv_set got=%b exp=1", invert); end
    total++; if (banner !== 1'b0) begin bad++; $display("FAIL inv_banner got=%b exp=0", banner); end
    repeat (2) cyc();
    vblank = 1'b0;
    repeat (3) cyc();
    btn_invert = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_next = 1'b1;
    vblank = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    fs_count = 0;
    repeat (20) cyc();
    total++; if (pattern_sel !== 4'd0) begin bad++; $display("FAIL rm_sel got=%0d exp=0", pattern_sel); end
    total++; if (fs_count !== 0) begin bad++; $display("FAIL rm_fs got=%0d exp=0", fs_count); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", frame_cnt); end
    vblank = 1'b0;
    btn_next = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    total = 0; bad = 0; fs_count = 0;
    reset = 1'b1; vblank = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0; btn_invert = 1'b0;
    test_reset();
    test_next_held();
    test_prev_wrap_banner();
    test_next_prev_same();
    test_auto();
    test_invert();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
